// File: rtl/gf_pow_seq_if.sv
// Request/result bundle for the GF(2^8) exponentiation engine.
// valid/ready contract: a request is taken on a rising edge where start=1 and busy=0; done is a one-cycle result strobe with y valid alongside it.
interface gf_pow_seq_if #(
  parameter int EXP_W = 8
);
  logic             start;
  logic [7:0]       x;
  logic [EXP_W-1:0] n;
  logic             busy;
  logic             done;
  logic [7:0]       y;

  modport master (output start, output x, output n, input busy, input done, input y);
  modport slave  (input start, input x, input n, output busy, output done, output y);
endinterface

// File: rtl/gf_pow_seq.sv
// Sequential y = x^n over GF(2^8), p(x)=x^8+x^6+x^5+x+1, using left-to-right square-and-multiply.
// Optional build macro GF_POW_CONST_TIME_EN: a multiply slot follows every square, giving a fixed latency.
module x_pow_n (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] w_sum;
  logic [7:0] w_sh;

  // Shift-and-add; each doubling of a folds x^8 back in as 0x63.
  always_comb begin
    w_sum = 8'h00;
    w_sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) w_sum = w_sum ^ w_sh;
      w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? 8'h63 : 8'h00);
    end
    p = w_sum;
  end
endmodule

module gf_pow_seq #(
  parameter int EXP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gf_pow_seq_if.slave          bus,
  output logic [1:0]           o_dbg_state
);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SQR, S_MUL, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_acc;
  logic [7:0]       r_x;
  logic [7:0]       r_y;
  logic [EXP_W-1:0] r_n;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       w_b;
  logic [7:0]       w_p;
  logic [7:0]       w_acc_nxt;
  logic             w_bit;
  logic             w_last;

  assign w_bit  = r_n[r_idx];
  assign w_last = (r_idx == '0);
  // Operand b is acc everywhere except MUL, so the multiplier never sees X.
  assign w_b    = (r_state == S_MUL) ? r_x : r_acc;

  x_pow_n u_mul (.a(r_acc), .b(w_b), .p(w_p));

  always_comb begin
    w_next    = r_state;
    w_acc_nxt = r_acc;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_SQR;
      S_SQR: begin
        w_acc_nxt = w_p;
`ifdef GF_POW_CONST_TIME_EN
        w_next = S_MUL;
`else
        if (w_bit)       w_next = S_MUL;
        else if (w_last) w_next = S_DONE;
        else             w_next = S_SQR;
`endif
      end
      S_MUL: begin
`ifdef GF_POW_CONST_TIME_EN
        w_acc_nxt = w_bit ? w_p : r_acc;
`else
        w_acc_nxt = w_p;
`endif
        w_next = w_last ? S_DONE : S_SQR;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 8'h00;
      r_x   <= 8'h00;
      r_n   <= '0;
      r_idx <= '0;
      r_y   <= 8'h00;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_x   <= bus.x;
        r_n   <= bus.n;
        r_acc <= 8'h01;
        r_idx <= IDX_W'(EXP_W - 1);
      end
      if (r_state == S_SQR || r_state == S_MUL) begin
        r_acc <= w_acc_nxt;
        if (w_next == S_SQR) r_idx <= r_idx - 1'b1;
        if (w_next == S_DONE) r_y <= w_acc_nxt;
      end
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.y       = r_y;
  assign o_dbg_state = r_state;
endmodule
